cache_ctrl_gen2: RTL

CACHE_CTRL_GEN2 -- requirements
Module: cache_ctrl_gen2

---
 rtl/cache_ctrl_pkg.sv | 53 +++++
 rtl/cache_ctrl_gen2_wait_ctr.sv | 33 +++
 rtl/cache_ctrl_gen2.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared types and elaboration-time helpers for the gen2 cache controller.
package cache_ctrl_pkg;

    // Controller states: check, evict, fill and write-through phases.
    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        RD_CHK  = 4'd1,
        WR_CHK  = 4'd2,
        EV_REQ  = 4'd3,
        EV_WAIT = 4'd4,
        EV_NEXT = 4'd5,
        FL_REQ  = 4'd6,
        FL_WAIT = 4'd7,
        FL_DATA = 4'd8,
        WT_REQ  = 4'd9,
        WT_WAIT = 4'd10,
        WT_DONE = 4'd11,
        WA_DONE = 4'd12
    } state_t;

    // All single-bit control outputs, decoded together each cycle.
    typedef struct packed {
        logic dready;
        logic w;
        logic wsel;
        logic rsel;
        logic mstrobe;
        logic mrw;
        logic set_dirty;
        logic clr_dirty;
    } ctrl_out_t;

    // The memory wait counter is sized for the largest legal WAIT_CYCLES.
    localparam int WAIT_CTR_W = 8;

    function automatic bit wait_cycles_legal(input int wc);
        return (wc >= 1) && (wc <= 255);
    endfunction

    function automatic bit line_words_legal(input int lw);
        return (lw == 1) || (lw == 2) || (lw == 4) || (lw == 8);
    endfunction

    function automatic bit write_back_legal(input int wb);
        return (wb == 0) || (wb == 1);
    endfunction

    // WordIdx keeps at least one bit even for single-word lines.
    function automatic int idx_width(input int lw);
        return (lw > 1) ? $clog2(lw) : 1;
    endfunction

endpackage

// File: rtl/cache_ctrl_gen2_wait_ctr.sv
// Memory wait counter: loaded on the request cycle, counts down during the
// wait phase and pulses o_done on the last wait cycle.
module wait_ctr_p
    import cache_ctrl_pkg::*;
#(
    parameter int COUNT = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_done
);

    localparam logic [WAIT_CTR_W-1:0] LOAD_VAL = WAIT_CTR_W'(COUNT);

    logic [WAIT_CTR_W-1:0] r_cnt;

    // Load COUNT on the request cycle, then decrement once per wait cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - WAIT_CTR_W'(1);
        end
    end

    // Done on the COUNT-th wait cycle, so the wait phase is exactly COUNT long.
    assign o_done = i_en && (r_cnt == WAIT_CTR_W'(1));

endmodule

// File: rtl/cache_ctrl_gen2.sv
// Cache controller: hit check, optional dirty-line eviction, line fill and
// write-through sequencing against a fixed-latency word memory.
module cache_ctrl_gen2
    import cache_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 4,
    parameter int LINE_WORDS  = 1,
    parameter int WRITE_BACK  = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              Strobe,
    input  logic                              DRW,
    input  logic                              M,
    input  logic                              V,
    input  logic                              D,
    output logic                              DReady,
    output logic                              W,
    output logic                              WSel,
    output logic                              RSel,
    output logic                              MStrobe,
    output logic                              MRW,
    output logic [idx_width(LINE_WORDS)-1:0]  WordIdx,
    output logic                              SetDirty,
    output logic                              ClrDirty
);

    localparam int             IW       = idx_width(LINE_WORDS);
    localparam logic [IW-1:0]  LAST_IDX = IW'(LINE_WORDS - 1);
    localparam bit             WB       = (WRITE_BACK != 0);

    // Reject illegal parameterisations at elaboration.
    if (!wait_cycles_legal(WAIT_CYCLES)) begin : g_bad_wait
        $error("cache_ctrl_gen2: WAIT_CYCLES must be 1..255");
    end
    if (!line_words_legal(LINE_WORDS)) begin : g_bad_line
        $error("cache_ctrl_gen2: LINE_WORDS must be 1, 2, 4 or 8");
    end
    if (!write_back_legal(WRITE_BACK)) begin : g_bad_wb
        $error("cache_ctrl_gen2: WRITE_BACK must be 0 or 1");
    end

    state_t         r_state;
    state_t         w_state_nxt;
    logic [IW-1:0]  r_word_idx;
    logic [IW-1:0]  w_word_idx_nxt;
    logic           r_hit;        // write-through: line hit seen in WR_CHK
    logic           w_hit_nxt;
    logic           r_wr;         // current request is a CPU write
    logic           w_wr_nxt;
    ctrl_out_t      w_out;
    logic           w_ctr_load;
    logic           w_ctr_en;
    logic           w_ctr_done;
    logic           w_line_hit;
    logic           w_dirty_victim;
    logic           w_last;

    assign w_line_hit     = M & V;
    assign w_dirty_victim = WB & V & D;
    assign w_last         = (r_word_idx == LAST_IDX);

    wait_ctr_p #(
        .COUNT (WAIT_CYCLES)
    ) u_wait_ctr (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_load  (w_ctr_load),
        .i_en    (w_ctr_en),
        .o_done  (w_ctr_done)
    );

    // State, word index and per-request flags; reset wins over everything.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_word_idx <= '0;
            r_hit      <= 1'b0;
            r_wr       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_word_idx <= w_word_idx_nxt;
            r_hit      <= w_hit_nxt;
            r_wr       <= w_wr_nxt;
        end
    end

    // Next-state and output decode; only the check states look at M/V.
    always_comb begin
        w_state_nxt    = r_state;
        w_word_idx_nxt = r_word_idx;
        w_hit_nxt      = r_hit;
        w_wr_nxt       = r_wr;
        w_out          = '0;
        w_ctr_load     = 1'b0;
        w_ctr_en       = 1'b0;

        case (r_state)
            IDLE: begin
                w_word_idx_nxt = '0;
                if (Strobe) begin
                    w_wr_nxt    = DRW;
                    w_hit_nxt   = 1'b0;
                    w_state_nxt = DRW ? WR_CHK : RD_CHK;
                end
            end

            RD_CHK: begin
                if (w_line_hit) begin
                    w_out.dready = 1'b1;
                    w_state_nxt  = IDLE;
                end else if (w_dirty_victim) begin
                    w_state_nxt  = EV_REQ;
                end else begin
                    w_state_nxt  = FL_REQ;
                end
            end

            WR_CHK: begin
                if (!WB) begin
                    w_hit_nxt   = w_line_hit;
                    w_state_nxt = WT_REQ;
                end else if (w_line_hit) begin
                    w_out.w         = 1'b1;
                    w_out.set_dirty = 1'b1;
                    w_out.dready    = 1'b1;
                    w_state_nxt     = IDLE;
                end else if (w_dirty_victim) begin
                    w_state_nxt = EV_REQ;
                end else begin
                    w_state_nxt = FL_REQ;
                end
            end

            EV_REQ: begin
                w_out.mstrobe = 1'b1;
                w_out.mrw     = 1'b1;
                w_out.rsel    = 1'b1;
                w_ctr_load    = 1'b1;
                w_state_nxt   = EV_WAIT;
            end

            EV_WAIT: begin
                w_out.mrw = 1'b1;
                w_ctr_en  = 1'b1;
                if (w_ctr_done) begin
                    w_state_nxt = EV_NEXT;
                end
            end

            EV_NEXT: begin
                if (w_last) begin
                    w_word_idx_nxt = '0;
                    w_state_nxt    = FL_REQ;
                end else begin
                    w_word_idx_nxt = r_word_idx + IW'(1);
                    w_state_nxt    = EV_REQ;
                end
            end

            FL_REQ: begin
                w_out.mstrobe = 1'b1;
                w_ctr_load    = 1'b1;
                w_state_nxt   = FL_WAIT;
            end

            FL_WAIT: begin
                w_ctr_en = 1'b1;
                if (w_ctr_done) begin
                    w_state_nxt = FL_DATA;
                end
            end

            FL_DATA: begin
                w_out.w    = 1'b1;
                w_out.wsel = 1'b1;
                if (w_last) begin
                    w_out.clr_dirty = 1'b1;
                    w_word_idx_nxt  = '0;
                    if (r_wr) begin
                        w_state_nxt = WA_DONE;
                    end else begin
                        w_out.dready = 1'b1;
                        w_state_nxt  = IDLE;
                    end
                end else begin
                    w_word_idx_nxt = r_word_idx + IW'(1);
                    w_state_nxt    = FL_REQ;
                end
            end

            WA_DONE: begin
                w_out.w         = 1'b1;
                w_out.set_dirty = 1'b1;
                w_out.dready    = 1'b1;
                w_state_nxt     = IDLE;
            end

            WT_REQ: begin
                w_out.mstrobe = 1'b1;
                w_out.mrw     = 1'b1;
                w_ctr_load    = 1'b1;
                w_state_nxt   = WT_WAIT;
            end

            WT_WAIT: begin
                w_out.mrw = 1'b1;
                w_ctr_en  = 1'b1;
                if (w_ctr_done) begin
                    w_state_nxt = WT_DONE;
                end
            end

            WT_DONE: begin
                w_out.dready = 1'b1;
                w_out.w      = r_hit;
                w_state_nxt  = IDLE;
            end

            default: begin
                w_word_idx_nxt = '0;
                w_state_nxt    = IDLE;
            end
        endcase
    end

    assign DReady   = w_out.dready;
    assign W        = w_out.w;
    assign WSel     = w_out.wsel;
    assign RSel     = w_out.rsel;
    assign MStrobe  = w_out.mstrobe;
    assign MRW      = w_out.mrw;
    assign SetDirty = w_out.set_dirty;
    assign ClrDirty = w_out.clr_dirty;
    assign WordIdx  = r_word_idx;

endmodule
